io_ram: RTL and testbench
=========================

IO_RAM -- requirements
Module: io_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning word width in bits (inbound FIFO buffer 8, outbound buffer 9 with bit 8 as address/data flag).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning address width; depth = 2**ADDR_W words (inbound 10, outbound 11).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; both ports are clocked on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1 bit: write enable.
REQ-006 SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-007 SHALL have port wr_data, input, DATA_W bits: write data.
REQ-008 SHALL have port rd_en, input, 1 bit: read enable.
REQ-009 SHALL have port rd_addr, input, ADDR_W bits: read address.
REQ-010 SHALL have port rd_data, output, DATA_W bits: read data.

Function
REQ-011 SHALL implement a simple dual-port RAM with one write port and one read port, both clocked by clk.
REQ-012 SHALL, on a rising edge with wr_en=1 and rst=0, store wr_data at wr_addr; the stored value is readable from the next cycle.
REQ-013 SHALL, on a rising edge with rd_en=1 and rst=0, load rd_data with mem[rd_addr]: read latency 1 cycle (base configuration).
REQ-014 SHALL hold rd_data unchanged while rd_en=0.
REQ-015 SHALL return the old (pre-write) contents when reading and writing the same address in the same cycle.
REQ-016 SHALL permit any rd_addr/wr_addr combination, including equal addresses and all-ones addresses (depth-1), with no wrap or bounds logic inside; pointer wrap is the caller's responsibility.
REQ-017 SHALL treat X-free operation as mandatory: uninitialised words SHALL read as zero, with all memory words initialised to 0 at time zero.

Reset
REQ-018 SHALL, while rst=1, force rd_data (and the output stage of REQ-021, if present) to 0 on each rising edge.
REQ-019 SHALL give a write priority over reset: a write with rst=1 and wr_en=1 still updates memory; reset never clears memory contents.
REQ-020 SHALL give reset priority over rd_en: a read issued in a reset cycle is discarded, and rd_data is 0 on the following cycle.

Configuration
REQ-021 SHALL, when macro IO_RAM_OUTREG_EN is defined, add one output register after the array read. Read latency becomes 2 cycles. Read-during-write on the same address still returns old data. Both stages are cleared by rst and both advance only when rd_en=1.
REQ-022 SHALL, when IO_RAM_OUTREG_EN is undefined, have read latency exactly 1 cycle per REQ-013.

Structure
REQ-023 SHALL take its shared constants from package io_ram_pkg. The package SHALL hold IRAM_DATA_W=8, IRAM_ADDR_W=10, ORAM_DATA_W=9 and ORAM_ADDR_W=11.
REQ-024 SHALL be a single module with no sub-modules. The array SHALL be coded as an inferable block RAM: a sized register array, one write process and one read process.

Verification
REQ-025 Write/read: write 8'hA5 @ 3, then rd_en with rd_addr=3 -> rd_data=8'hA5 one cycle later (two cycles with IO_RAM_OUTREG_EN).
REQ-026 Collision: mem[5]=8'h11; same cycle write 8'h22 @ 5 and read 5 -> rd_data=8'h11; next read -> 8'h22.
REQ-027 Reset: rd_data=8'hFF, assert rst one cycle -> rd_data=0; mem contents intact (subsequent read returns 8'hFF).
REQ-028 Boundary/ORAM width: DATA_W=9, ADDR_W=11; write 9'h1C4 @ 2047 and 9'h0FF @ 0 -> reads return 9'h1C4 and 9'h0FF with no aliasing.
REQ-029 Hold/init: read an unwritten address -> 0; then drop rd_en while changing rd_addr -> rd_data unchanged.
REQ-030 Streaming: 1024 consecutive writes of addr[7:0] followed by 1024 pipelined reads, one per cycle -> every word matches, 1-cycle skew.

Source files
------------

// File: rtl/io_ram_pkg.sv
// Shared geometry for the inbound (IRAM) and outbound (ORAM) FIFO buffers.
// The outbound word carries an address/data flag in bit 8.
package io_ram_pkg;

  localparam int IRAM_DATA_W = 8;
  localparam int IRAM_ADDR_W = 10;
  localparam int ORAM_DATA_W = 9;
  localparam int ORAM_ADDR_W = 11;

endpackage

// File: rtl/io_ram.sv
// Simple dual-port block RAM: one write port, one read port, single clock, old-data on collision.
// Optional IO_RAM_OUTREG_EN adds an output register (read latency 2 instead of 1).
module io_ram
  import io_ram_pkg::*;
#(
  parameter int DATA_W = IRAM_DATA_W,
  parameter int ADDR_W = IRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Zero-initialised so unwritten words never read as X; reset never clears the array.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] r_rd;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0;
    end else if (rd_en) begin
      r_rd <= r_mem[rd_addr];
    end
  end

`ifdef IO_RAM_OUTREG_EN
  logic [DATA_W-1:0] r_out;

  // Second stage advances in lock-step with the array read, not freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else if (rd_en) begin
      r_out <= r_rd;
    end
  end

  assign rd_data = r_out;
`else
  assign rd_data = r_rd;
`endif

endmodule

// File: tb/tb_io_ram.sv
// Self-checking bench for io_ram: directed table, streaming, ORAM geometry and random vs. a reference model.
// Adapts expected latency to IO_RAM_OUTREG_EN.
module tb_io_ram;

`ifdef IO_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en;
  logic [9:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  logic        b_rst, b_wr_en, b_rd_en;
  logic [10:0] b_wr_addr, b_rd_addr;
  logic [8:0]  b_wr_data, b_rd_data;

  int total = 0;
  int bad   = 0;

  // Reference model: memory contents plus the results of the last LAT accepted reads.
  logic [7:0] m_mem [1024];
  logic [7:0] m_q [$];

  io_ram dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  io_ram #(.DATA_W(9), .ADDR_W(11)) dut_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       we;
    logic [9:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [9:0] ra;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < LAT; i++) m_q.push_back(8'h00);
  endtask

  task automatic step();
    logic [7:0] rv;
    @(posedge clk);
    rv = m_mem[rd_addr];
    if (rst) model_reset();
    else if (rd_en) begin
      m_q.push_back(rv);
      void'(m_q.pop_front());
    end
    if (wr_en) m_mem[wr_addr] = wr_data;
    #1;
  endtask

  task automatic idle_a();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
    model_reset();
    idle_a();
    b_rst = 1'b1; b_wr_en = 1'b0; b_rd_en = 1'b0;
    b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;

    //             rst   we    wa      wd     re    ra      e1     e2
    tbl[0]  = '{1'b0, 1'b1, 10'd3,    8'hA5, 1'b0, 10'd0,    8'h00, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b1, 10'd3,    8'hA5, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b1, 10'd7,    8'h00, 8'hA5};
    tbl[3]  = '{1'b0, 1'b1, 10'd5,    8'h11, 1'b1, 10'd7,    8'h00, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 10'd5,    8'h22, 1'b1, 10'd5,    8'h11, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b1, 10'd5,    8'h22, 8'h11};
    tbl[6]  = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b0, 10'd3,    8'h22, 8'h11};
    tbl[7]  = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b1, 10'd3,    8'hA5, 8'h22};
    tbl[8]  = '{1'b0, 1'b1, 10'd3,    8'hFF, 1'b1, 10'd3,    8'hA5, 8'hA5};
    tbl[9]  = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b1, 10'd3,    8'hFF, 8'hA5};
    tbl[10] = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b1, 10'd3,    8'hFF, 8'hFF};
    tbl[11] = '{1'b1, 1'b0, 10'd0,    8'h00, 1'b1, 10'd3,    8'h00, 8'h00};
    tbl[12] = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b0, 10'd3,    8'h00, 8'h00};
    tbl[13] = '{1'b1, 1'b1, 10'd9,    8'h3C, 1'b1, 10'd9,    8'h00, 8'h00};
    tbl[14] = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b1, 10'd9,    8'h3C, 8'h00};
    tbl[15] = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b1, 10'd3,    8'hFF, 8'h3C};
    tbl[16] = '{1'b0, 1'b1, 10'd1023, 8'h77, 1'b1, 10'd1023, 8'h00, 8'hFF};
    tbl[17] = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b1, 10'd1023, 8'h77, 8'h00};
    tbl[18] = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b1, 10'd0,    8'h00, 8'h77};
    tbl[19] = '{1'b0, 1'b0, 10'd0,    8'h00, 1'b0, 10'd1023, 8'h00, 8'h77};

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("reset_a", {1'b0, rd_data}, 9'h000);
    check("reset_b", b_rd_data, 9'h000);
    b_rst = 1'b0;

    // Directed table
    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst; wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_en = tbl[i].re; rd_addr = tbl[i].ra;
      step();
      check($sformatf("table[%0d]", i), {1'b0, rd_data},
            {1'b0, (LAT == 1) ? tbl[i].e1 : tbl[i].e2});
    end
    idle_a();

    // Streaming: 1024 writes then 1024 back-to-back reads
    for (int i = 0; i < 1024; i++) begin
      wr_en = 1'b1; wr_addr = i[9:0]; wr_data = i[7:0]; rd_en = 1'b0;
      step();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 1024 + LAT - 1; k++) begin
      rd_en = 1'b1;
      rd_addr = (k < 1024) ? k[9:0] : 10'd0;
      step();
      if (k >= LAT - 1) begin
        int src;
        src = k - LAT + 1;
        check($sformatf("stream[%0d]", src), {1'b0, rd_data}, {1'b0, src[7:0]});
      end
    end
    idle_a();

    // ORAM geometry: top address and address 0 must not alias
    b_wr_en = 1'b1; b_wr_addr = 11'd2047; b_wr_data = 9'h1C4;
    step();
    b_wr_addr = 11'd0; b_wr_data = 9'h0FF;
    step();
    b_wr_en = 1'b0; b_rd_en = 1'b1; b_rd_addr = 11'd2047;
    repeat (LAT) step();
    check("oram_2047", b_rd_data, 9'h1C4);
    b_rd_addr = 11'd0;
    repeat (LAT) step();
    check("oram_0", b_rd_data, 9'h0FF);
    b_rd_addr = 11'd1023;
    repeat (LAT) step();
    check("oram_1023", b_rd_data, 9'h000);
    b_rd_en = 1'b0; b_rd_addr = 11'd2047;
    step();
    check("oram_hold", b_rd_data, 9'h000);

    // Random traffic against the reference model
    rst = 1'b1;
    step();
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(31) == 0);
      wr_en   = $urandom_range(1);
      rd_en   = ($urandom_range(3) != 0);
      wr_addr = ($urandom_range(7) == 0) ? 10'h3FF : 10'($urandom_range(15));
      rd_addr = ($urandom_range(7) == 0) ? 10'h3FF : 10'($urandom_range(15));
      wr_data = 8'($urandom);
      step();
      check($sformatf("random[%0d]", n), {1'b0, rd_data}, {1'b0, m_q[0]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
